// File: rtl/debug_pkg.sv
// Shared constants for the debug loader: host command codes, reply bytes and FSM states.
package debug_pkg;

    localparam int          DBG_NB_DATA  = 8;
    localparam int          DBG_NB_WORD  = 32;
    localparam int          DBG_NB_ADDR  = 8;
    localparam logic [7:0]  DBG_ACK_BYTE = 8'hAA;
    localparam logic [7:0]  DBG_NAK_BYTE = 8'h55;

    localparam logic [7:0]  CMD_LOAD = 8'h01;
    localparam logic [7:0]  CMD_RUN  = 8'h02;
    localparam logic [7:0]  CMD_STEP = 8'h03;
    localparam logic [7:0]  CMD_HALT = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_CNT  = 3'd1,
        ST_GET_BYTE = 3'd2,
        ST_WRITE    = 3'd3,
        ST_STEP     = 3'd4,
        ST_SEND     = 3'd5,
        ST_WAIT_TX  = 3'd6
    } state_e;

endpackage

// File: rtl/debug_loader_word_assembler.sv
// Packs successive bytes little-endian into one instruction word; word_done_o flags the last byte.
module word_assembler #(
    parameter int NB_DATA = 8,
    parameter int NB_WORD = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               byte_valid_i,
    input  logic [NB_DATA-1:0] byte_i,
    output logic [NB_WORD-1:0] word_o,
    output logic               word_done_o
);

    localparam int                NB_IDX   = $clog2(NB_WORD / NB_DATA);
    localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(NB_WORD / NB_DATA - 1);

    logic [NB_IDX-1:0]  idx_q,  idx_d;
    logic [NB_WORD-1:0] word_q, word_d;

    // Byte placement and index advance; clear restarts a word from lane 0.
    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear_i) begin
            idx_d  = '0;
            word_d = '0;
        end else if (byte_valid_i) begin
            word_d[idx_q*NB_DATA +: NB_DATA] = byte_i;
            idx_d = idx_q + NB_IDX'(1);
        end else begin
            idx_d  = idx_q;
            word_d = word_q;
        end
    end

    // Assembly state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign word_o      = word_q;
    assign word_done_o = byte_valid_i && (idx_q == LAST_IDX);

endmodule

// File: rtl/debug_loader.sv
// Host command decoder and instruction-memory loader between the UART rx and tx paths.
module debug_loader
    import debug_pkg::*;
#(
    parameter int               NB_DATA  = DBG_NB_DATA,
    parameter int               NB_WORD  = DBG_NB_WORD,
    parameter int               NB_ADDR  = DBG_NB_ADDR,
    parameter logic [NB_DATA-1:0] ACK_BYTE = DBG_ACK_BYTE,
    parameter logic [NB_DATA-1:0] NAK_BYTE = DBG_NAK_BYTE
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               rx_empty_i,
    input  logic [NB_DATA-1:0] rx_data_i,
    output logic               rx_rd_o,
    output logic [NB_DATA-1:0] tx_data_o,
    output logic               tx_start_o,
    input  logic               tx_done_i,
    output logic               imem_wr_en_o,
    output logic [NB_ADDR-1:0] imem_addr_o,
    output logic [NB_WORD-1:0] imem_data_o,
    output logic               cpu_run_o,
    output logic               cpu_step_o,
    output logic               busy_o
);

    // One extra bit so a count byte of zero can stand for 2^NB_DATA words.
    localparam int NB_CNT = NB_DATA + 1;

    state_e             state_q, state_d;
    logic               run_q,   run_d;
    logic [NB_DATA-1:0] reply_q, reply_d;
    logic [NB_CNT-1:0]  cnt_q,   cnt_d;
    logic [NB_ADDR-1:0] addr_q,  addr_d;

    logic               rx_rd_s;
    logic               byte_valid_s;
    logic               asm_clear_s;
    logic               wr_en_s;
    logic               step_s;
    logic               tx_start_s;
    logic               word_done_s;
    logic [NB_WORD-1:0] word_s;

    word_assembler #(
        .NB_DATA (NB_DATA),
        .NB_WORD (NB_WORD)
    ) u_word_assembler (
        .clock        (clock),
        .reset        (reset),
        .clear_i      (asm_clear_s),
        .byte_valid_i (byte_valid_s),
        .byte_i       (rx_data_i),
        .word_o       (word_s),
        .word_done_o  (word_done_s)
    );

    // Next-state, datapath updates and strobes for the command FSM.
    always_comb begin
        state_d      = state_q;
        run_d        = run_q;
        reply_d      = reply_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        rx_rd_s      = 1'b0;
        byte_valid_s = 1'b0;
        asm_clear_s  = 1'b0;
        wr_en_s      = 1'b0;
        step_s       = 1'b0;
        tx_start_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_empty_i) begin
                    rx_rd_s = 1'b1;
                    case (rx_data_i)
                        NB_DATA'(CMD_LOAD): begin
                            run_d   = 1'b0;
                            state_d = ST_GET_CNT;
                        end
                        NB_DATA'(CMD_RUN): begin
                            run_d   = 1'b1;
                            reply_d = ACK_BYTE;
                            state_d = ST_SEND;
                        end
                        NB_DATA'(CMD_HALT): begin
                            run_d   = 1'b0;
                            reply_d = ACK_BYTE;
                            state_d = ST_SEND;
                        end
                        NB_DATA'(CMD_STEP): begin
                            if (run_q) begin
                                reply_d = NAK_BYTE;
                                state_d = ST_SEND;
                            end else begin
                                state_d = ST_STEP;
                            end
                        end
                        default: begin
                            reply_d = NAK_BYTE;
                            state_d = ST_SEND;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GET_CNT: begin
                if (!rx_empty_i) begin
                    rx_rd_s     = 1'b1;
                    asm_clear_s = 1'b1;
                    addr_d      = '0;
                    cnt_d       = (rx_data_i == '0) ? {1'b1, {NB_DATA{1'b0}}} : {1'b0, rx_data_i};
                    state_d     = ST_GET_BYTE;
                end else begin
                    state_d = ST_GET_CNT;
                end
            end
            ST_GET_BYTE: begin
                if (!rx_empty_i) begin
                    rx_rd_s      = 1'b1;
                    byte_valid_s = 1'b1;
                    state_d      = word_done_s ? ST_WRITE : ST_GET_BYTE;
                end else begin
                    state_d = ST_GET_BYTE;
                end
            end
            ST_WRITE: begin
                wr_en_s = 1'b1;
                addr_d  = addr_q + NB_ADDR'(1);
                cnt_d   = cnt_q - NB_CNT'(1);
                if (cnt_q == NB_CNT'(1)) begin
                    reply_d = ACK_BYTE;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_GET_BYTE;
                end
            end
            ST_STEP: begin
                step_s  = 1'b1;
                reply_d = ACK_BYTE;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                tx_start_s = 1'b1;
                state_d    = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (tx_done_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_TX;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
            reply_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            reply_q <= reply_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    assign rx_rd_o      = rx_rd_s;
    assign tx_data_o    = reply_q;
    assign tx_start_o   = tx_start_s;
    assign imem_wr_en_o = wr_en_s;
    assign imem_addr_o  = addr_q;
    assign imem_data_o  = word_s;
    assign cpu_run_o    = run_q;
    assign cpu_step_o   = step_s;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_debug_loader.sv
// Directed bench for debug_loader: byte-queue UART source, auto tx_done responder, event logs.
module tb_debug_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx_empty_i = 1'b1;
    logic [7:0]  rx_data_i = 8'h00;
    logic        tx_done_i = 1'b0;
    logic        rx_rd_o;
    logic [7:0]  tx_data_o;
    logic        tx_start_o;
    logic        imem_wr_en_o;
    logic [7:0]  imem_addr_o;
    logic [31:0] imem_data_o;
    logic        cpu_run_o;
    logic        cpu_step_o;
    logic        busy_o;

    debug_loader dut (
        .clock        (clock),
        .reset        (reset),
        .rx_empty_i   (rx_empty_i),
        .rx_data_i    (rx_data_i),
        .rx_rd_o      (rx_rd_o),
        .tx_data_o    (tx_data_o),
        .tx_start_o   (tx_start_o),
        .tx_done_i    (tx_done_i),
        .imem_wr_en_o (imem_wr_en_o),
        .imem_addr_o  (imem_addr_o),
        .imem_data_o  (imem_data_o),
        .cpu_run_o    (cpu_run_o),
        .cpu_step_o   (cpu_step_o),
        .busy_o       (busy_o)
    );

    always #5 clock = ~clock;

    logic [7:0]  rxq[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int step_cnt = 0;
    int dbl_wr   = 0;
    int dbl_step = 0;
    int tdc      = 0;
    int cyc      = 0;
    int step_cyc = 0;
    int tx_cyc   = 0;
    bit prev_wr   = 1'b0;
    bit prev_step = 1'b0;
    bit pop_pend  = 1'b0;
    logic [7:0] popped;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        rxq.push_back(b);
    endtask

    // UART receive buffer model: pop just after the edge that consumed the head byte.
    always @(posedge clock) begin
        cyc++;
        #1;
        if (pop_pend && rxq.size() > 0) popped = rxq.pop_front();
        rx_empty_i = (rxq.size() == 0);
        rx_data_i  = (rxq.size() == 0) ? 8'h00 : rxq[0];
    end

    // Output monitor and transmitter model, sampled mid-cycle.
    always @(negedge clock) begin
        pop_pend = rx_rd_o;
        if (imem_wr_en_o) begin
            wa_q.push_back(imem_addr_o);
            wd_q.push_back(imem_data_o);
            if (prev_wr) dbl_wr++;
        end
        prev_wr = imem_wr_en_o;
        if (cpu_step_o) begin
            step_cnt++;
            step_cyc = cyc;
            if (prev_step) dbl_step++;
        end
        prev_step = cpu_step_o;
        if (tx_start_o) begin
            tx_q.push_back(tx_data_o);
            tx_cyc = cyc;
            tdc = 3;
        end
        if (tx_done_i) begin
            tx_done_i = 1'b0;
        end else if (tdc > 0) begin
            tdc--;
            if (tdc == 0) tx_done_i = 1'b1;
        end
    end

    task automatic wait_replies(input int n, input int budget);
        int c = 0;
        bit ok = 1'b0;
        while (!ok && c < budget) begin
            @(negedge clock);
            #1;
            c++;
            ok = (tx_q.size() >= n) && !busy_o && (rxq.size() == 0) && !tx_done_i;
        end
        check_eq("reply_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic clear_logs;
        tx_q.delete();
        wa_q.delete();
        wd_q.delete();
    endtask

    initial begin
        int bad_addr;
        int bad_data;
        logic [7:0] iv;

        // Reset and idle
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("rst_busy",   {31'd0, busy_o},       32'd0);
        check_eq("rst_rx_rd",  {31'd0, rx_rd_o},      32'd0);
        check_eq("rst_tx_st",  {31'd0, tx_start_o},   32'd0);
        check_eq("rst_tx_dat", {24'd0, tx_data_o},    32'd0);
        check_eq("rst_wr_en",  {31'd0, imem_wr_en_o}, 32'd0);
        check_eq("rst_addr",   {24'd0, imem_addr_o},  32'd0);
        check_eq("rst_data",   imem_data_o,           32'd0);
        check_eq("rst_run",    {31'd0, cpu_run_o},    32'd0);
        check_eq("rst_step",   {31'd0, cpu_step_o},   32'd0);

        // LOAD two words
        clear_logs();
        push(8'h01); push(8'h02);
        push(8'h78); push(8'h56); push(8'h34); push(8'h12);
        push(8'hEF); push(8'hBE); push(8'hAD); push(8'hDE);
        wait_replies(1, 200);
        check_eq("load_nwr", wa_q.size(), 32'd2);
        if (wa_q.size() == 2) begin
            check_eq("load_a0", {24'd0, wa_q[0]}, 32'd0);
            check_eq("load_d0", wd_q[0], 32'h12345678);
            check_eq("load_a1", {24'd0, wa_q[1]}, 32'd1);
            check_eq("load_d1", wd_q[1], 32'hDEADBEEF);
        end
        check_eq("load_nrep", tx_q.size(), 32'd1);
        if (tx_q.size() > 0) check_eq("load_ack", {24'd0, tx_q[0]}, 32'hAA);
        check_eq("load_dblwr", dbl_wr, 32'd0);

        // RUN then STEP while running
        clear_logs();
        push(8'h02); push(8'h03);
        wait_replies(2, 100);
        if (tx_q.size() == 2) begin
            check_eq("run_ack",  {24'd0, tx_q[0]}, 32'hAA);
            check_eq("step_nak", {24'd0, tx_q[1]}, 32'h55);
        end else begin
            check_eq("run_nrep", tx_q.size(), 32'd2);
        end
        check_eq("run_level", {31'd0, cpu_run_o}, 32'd1);
        check_eq("run_nostep", step_cnt, 32'd0);

        // HALT then STEP
        clear_logs();
        push(8'h04); push(8'h03);
        wait_replies(2, 100);
        if (tx_q.size() == 2) begin
            check_eq("halt_ack", {24'd0, tx_q[0]}, 32'hAA);
            check_eq("step_ack", {24'd0, tx_q[1]}, 32'hAA);
        end else begin
            check_eq("halt_nrep", tx_q.size(), 32'd2);
        end
        check_eq("halt_level", {31'd0, cpu_run_o}, 32'd0);
        check_eq("step_cnt", step_cnt, 32'd1);
        check_eq("step_lat", tx_cyc - step_cyc, 32'd1);
        check_eq("step_dbl", dbl_step, 32'd0);

        // Unknown command
        clear_logs();
        push(8'h7F);
        wait_replies(1, 100);
        if (tx_q.size() > 0) check_eq("unk_nak", {24'd0, tx_q[0]}, 32'h55);
        check_eq("unk_idle", {31'd0, busy_o}, 32'd0);
        check_eq("unk_dout", {24'd0, tx_data_o}, 32'h55);

        // Reset in the middle of a word
        clear_logs();
        push(8'h01); push(8'h01); push(8'h11); push(8'h22);
        begin
            int c = 0;
            while (rxq.size() != 0 && c < 50) begin
                @(negedge clock);
                #1;
                c++;
            end
            check_eq("mid_drain", {31'd0, rxq.size() == 0}, 32'd1);
        end
        check_eq("mid_busy_pre", {31'd0, busy_o}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check_eq("mid_busy",  {31'd0, busy_o},      32'd0);
        check_eq("mid_data",  imem_data_o,          32'd0);
        check_eq("mid_txdat", {24'd0, tx_data_o},   32'd0);
        check_eq("mid_wr",    {31'd0, imem_wr_en_o}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        push(8'h01); push(8'h01); push(8'h01); push(8'h00); push(8'h00); push(8'h00);
        wait_replies(1, 100);
        check_eq("post_nwr", wa_q.size(), 32'd1);
        if (wa_q.size() == 1) begin
            check_eq("post_a0", {24'd0, wa_q[0]}, 32'd0);
            check_eq("post_d0", wd_q[0], 32'h00000001);
        end
        if (tx_q.size() > 0) check_eq("post_ack", {24'd0, tx_q[0]}, 32'hAA);

        // LOAD with count 0 = 256 words, back to back
        clear_logs();
        push(8'h01); push(8'h00);
        for (int i = 0; i < 256; i++) begin
            iv = 8'(i);
            push(iv); push(~iv); push(8'h5A); push(iv);
        end
        wait_replies(1, 3000);
        check_eq("full_nwr", wa_q.size(), 32'd256);
        bad_addr = 0;
        bad_data = 0;
        for (int i = 0; i < wa_q.size(); i++) begin
            iv = 8'(i);
            if (wa_q[i] !== iv) bad_addr++;
            if (wd_q[i] !== {iv, 8'h5A, ~iv, iv}) bad_data++;
        end
        check_eq("full_badaddr", bad_addr, 32'd0);
        check_eq("full_baddata", bad_data, 32'd0);
        check_eq("full_wrap",   {24'd0, imem_addr_o}, 32'd0);
        check_eq("full_nrep",   tx_q.size(), 32'd1);
        if (tx_q.size() > 0) check_eq("full_ack", {24'd0, tx_q[0]}, 32'hAA);
        check_eq("full_dblwr",  dbl_wr, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_loader.md
Name: debug_loader

Overview:
Command decoder and program loader sitting directly downstream of the UART receive path and upstream of its transmit path.
- Pops received bytes and interprets them as host commands.
- Assembles 4-byte little-endian instruction words and writes them into the MIPS instruction memory.
- Controls CPU run/step and returns a one-byte ACK/NAK through the UART transmitter for every command.

Parameters:
NB_DATA, 8, UART byte width
NB_WORD, 32, instruction word width (must be 4*NB_DATA)
NB_ADDR, 8, instruction memory word-address width
ACK_BYTE, 8'hAA, success reply
NAK_BYTE, 8'h55, error/unknown-command reply

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_empty_i  in  1  UART receive buffer empty; 0 = rx_data_i valid
rx_data_i  in  NB_DATA  head byte of UART receive buffer
rx_rd_o  out  1  pop strobe; byte consumed on the same rising edge
tx_data_o  out  NB_DATA  reply byte to UART transmitter
tx_start_o  out  1  one-cycle pulse, starts transmission of tx_data_o
tx_done_i  in  1  transmitter finished current byte
imem_wr_en_o  out  1  instruction memory write enable
imem_addr_o  out  NB_ADDR  instruction memory word address
imem_data_o  out  NB_WORD  instruction word
cpu_run_o  out  1  level: CPU free-running
cpu_step_o  out  1  one-cycle pulse: CPU executes one clock
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs 0; word counter, address, byte index and assembly register cleared. Instruction memory contents untouched. Reset mid-load discards the partial word.
- Commands: 0x01 LOAD, 0x02 RUN, 0x03 STEP, 0x04 HALT. Any other code: NAK.
- rx_rd_o = (state in IDLE, GET_CNT, GET_BYTE) and !rx_empty_i (combinational). rx_data_i is captured on that edge. The source updates empty/data by the next edge, so one pop per cycle is allowed.
- States: IDLE, GET_CNT, GET_BYTE, WRITE, STEP, SEND, WAIT_TX.
- IDLE, byte popped:
  - LOAD: forces cpu_run_o=0, then goes to GET_CNT.
  - RUN: cpu_run_o=1, reply ACK (SEND).
  - HALT: cpu_run_o=0, reply ACK.
  - STEP: if cpu_run_o=1, reply NAK; else go to STEP.
  - Other: reply NAK.
- GET_CNT: popped byte N = word count; N=0 means 256. Address register is cleared to 0. Go to GET_BYTE.
- GET_BYTE: byte k (k=0..3) goes to word bits [8k+7:8k]. After k=3, go to WRITE.
- WRITE (exactly one cycle): imem_wr_en_o=1 with imem_addr_o/imem_data_o stable. Address increments and wraps modulo 2^NB_ADDR; count decrements. If count reaches 0, reply ACK; else return to GET_BYTE with k=0.
- STEP (one cycle): cpu_step_o=1, then reply ACK.
- SEND (one cycle): tx_start_o=1, tx_data_o = reply byte (held until next reply). Then WAIT_TX.
- WAIT_TX: stay until tx_done_i=1, then IDLE. tx_done_i is ignored outside WAIT_TX. No rx pops occur in SEND/WAIT_TX/WRITE/STEP; bytes stay buffered upstream.
- Latency, command popped at edge N:
  - RUN/HALT/NAK: tx_start_o high in cycle N+1.
  - STEP: cpu_step_o in N+1, tx_start_o in N+2.
  - Last data byte of a word popped at N: imem_wr_en_o in N+1.
- imem_wr_en_o and cpu_step_o are never high for more than one consecutive cycle.

Decomposition:
- Shared package debug_pkg: command codes (CMD_LOAD/RUN/STEP/HALT), ACK/NAK defaults, state encoding localparams.
- One sub-module: word_assembler. Byte index counter plus NB_WORD shift/placement register. Inputs byte_valid, byte, clear; outputs word and word_done.

Test Plan:
- Reset then idle, rx_empty_i=1 -> all outputs 0, busy_o=0, no rx_rd_o.
- LOAD, N=2, bytes 78 56 34 12 EF BE AD DE -> imem writes addr0=0x12345678, addr1=0xDEADBEEF. Each write enable is one cycle. Then tx_start_o with 0xAA, busy_o until tx_done_i.
- RUN then STEP -> ACK, cpu_run_o=1, then NAK (0x55), cpu_step_o never pulses. HALT then STEP -> ACK, cpu_run_o=0, then one cpu_step_o pulse and ACK.
- Unknown byte 0x7F -> tx_data_o=0x55 pulse, state returns to IDLE after tx_done_i.
- Reset asserted after 2 data bytes of a LOAD -> outputs 0 immediately (async). Following LOAD N=1, bytes 01 00 00 00 -> write addr0=0x00000001 (no stale bytes).
- LOAD N=0 with 256 words, back-to-back bytes (rx_empty_i held 0) -> 256 writes at addr 0..255, address wraps to 0, single ACK.
